// File: rtl/dec_scoreboard.sv
// Registered write-enable decoder with a per-register busy scoreboard,
// RAW/WAW issue gating and an incremental busy counter.

module dec_scoreboard_cell #(
    parameter bit MASK = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic wb_hit,
    input  logic set_hit,
    output logic dec,
    output logic busy,
    output logic clr,
    output logic pend
);
    // A masked cell never decodes and never holds state; the register folds away.
    assign dec  = wb_hit & ~MASK;
    assign clr  = dec & busy;
    assign pend = busy & ~clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= 1'b0;
        else        busy <= (pend | set_hit) & ~MASK;
    end
endmodule

module dec_scoreboard #(
    parameter int AW       = 5,
    parameter int NREG     = 2**AW,
    parameter int ZERO_REG = 1,
    parameter int OUT_REG  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_addr,
    input  logic [AW-1:0]   src_a_addr,
    input  logic [AW-1:0]   src_b_addr,
    output logic            iss_ready,
    output logic            hazard,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_addr,
    output logic [NREG-1:0] we_onehot,
    output logic [NREG-1:0] busy,
    output logic [AW:0]     busy_cnt,
    output logic            wb_err
);
    logic [NREG-1:0] wb_hit, set_hit, wb_dec, clr, pend;
    logic            iss_fire, iss_masked, wb_masked, cnt_inc, cnt_dec;

    assign iss_fire   = iss_valid & iss_ready;
    assign iss_masked = (ZERO_REG != 0) && (iss_addr == '0);
    assign wb_masked  = (ZERO_REG != 0) && (wb_addr == '0);

    for (genvar i = 0; i < NREG; i++) begin : g_reg
        assign wb_hit[i]  = wb_valid & (wb_addr == AW'(i));
        assign set_hit[i] = iss_fire & (iss_addr == AW'(i));

        dec_scoreboard_cell #(
            .MASK((ZERO_REG != 0) && (i == 0))
        ) u_cell (
            .clk     (clk),
            .rst_n   (rst_n),
            .wb_hit  (wb_hit[i]),
            .set_hit (set_hit[i]),
            .dec     (wb_dec[i]),
            .busy    (busy[i]),
            .clr     (clr[i]),
            .pend    (pend[i])
        );
    end

    // Same-cycle write-back releases its register, so it never stalls the issue.
    assign hazard    = pend[src_a_addr] | pend[src_b_addr];
    assign iss_ready = ~hazard & ~pend[iss_addr];

    // An accepted issue always targets a non-pending bit, so it is always a new one.
    assign cnt_inc = iss_fire & ~iss_masked;
    assign cnt_dec = |clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt <= '0;
            wb_err   <= 1'b0;
        end else begin
            if (!(cnt_inc && !cnt_dec && busy_cnt == (AW+1)'(NREG)))
                busy_cnt <= busy_cnt + {{AW{1'b0}}, cnt_inc} - {{AW{1'b0}}, cnt_dec};
            wb_err <= wb_valid & ~busy[wb_addr] & ~wb_masked;
        end
    end

    if (OUT_REG != 0) begin : g_we_reg
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) we_onehot <= '0;
            else        we_onehot <= wb_dec;
        end
    end else begin : g_we_comb
        assign we_onehot = wb_dec;
    end
endmodule
